// File: rtl/game_sprite_motion.sv
// Sprite position integrator: advances (x, y) by a signed step on each movement strobe.
// It reflects off the left, right and top edges, and ends the flight at the bottom edge.
module game_sprite_motion #(
    parameter int width_x       = 10,
    parameter int width_y       = 10,
    parameter int width_step    = 4,
    parameter int screen_width  = 640,
    parameter int screen_height = 480,
    parameter int sprite_width  = 8,
    parameter int sprite_height = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         strobe,
    input  logic                         launch,
    input  logic [width_x-1:0]           launch_x,
    input  logic [width_y-1:0]           launch_y,
    input  logic signed [width_step-1:0] launch_dx,
    input  logic signed [width_step-1:0] launch_dy,
    input  logic                         pause,
    output logic [width_x-1:0]           x,
    output logic [width_y-1:0]           y,
    output logic signed [width_step-1:0] dx,
    output logic signed [width_step-1:0] dy,
    output logic                         active,
    output logic                         bounce,
    output logic                         lost
);

    localparam int XMAX = screen_width - sprite_width;
    localparam int YMAX = screen_height - sprite_height;
    localparam logic [width_x-1:0]        XMAX_C = width_x'(XMAX);
    localparam logic [width_y-1:0]        YMAX_C = width_y'(YMAX);
    localparam logic signed [width_x+1:0] XMAX_S = (width_x+2)'(XMAX);
    localparam logic signed [width_y+1:0] YMAX_S = (width_y+2)'(YMAX);

    typedef enum logic {IDLE, MOVE} state_t;

    state_t                         state_q, state_d;
    logic [width_x-1:0]             x_q, x_d;
    logic [width_y-1:0]             y_q, y_d;
    logic signed [width_step-1:0]   dx_q, dx_d;
    logic signed [width_step-1:0]   dy_q, dy_d;
    logic                           bounce_q, bounce_d;
    logic                           lost_q, lost_d;
    logic signed [width_x+1:0]      nx;
    logic signed [width_y+1:0]      ny;

    // The most negative step becomes its neighbour so that -step always fits.
    function automatic logic signed [width_step-1:0] sat_step(input logic signed [width_step-1:0] s);
        if (s == {1'b1, {(width_step-1){1'b0}}})
            return {s[width_step-1:1], 1'b1};
        return s;
    endfunction

    function automatic logic [width_x-1:0] clamp_x(input logic [width_x-1:0] v);
        return (v > XMAX_C) ? XMAX_C : v;
    endfunction

    function automatic logic [width_y-1:0] clamp_y(input logic [width_y-1:0] v);
        return (v > YMAX_C) ? YMAX_C : v;
    endfunction

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        dx_d     = dx_q;
        dy_d     = dy_q;
        bounce_d = 1'b0;
        lost_d   = 1'b0;
        // Two extra bits: one for the sign, one so x + dx can never wrap.
        nx = $signed({2'b00, x_q}) + $signed({{(width_x+2-width_step){dx_q[width_step-1]}}, dx_q});
        ny = $signed({2'b00, y_q}) + $signed({{(width_y+2-width_step){dy_q[width_step-1]}}, dy_q});

        if (launch) begin
            state_d = MOVE;
            x_d     = clamp_x(launch_x);
            y_d     = clamp_y(launch_y);
            dx_d    = sat_step(launch_dx);
            dy_d    = sat_step(launch_dy);
        end else if (state_q == MOVE && strobe && !pause) begin
            if (nx < 0) begin
                x_d      = '0;
                dx_d     = -dx_q;
                bounce_d = 1'b1;
            end else if (nx > XMAX_S) begin
                x_d      = XMAX_C;
                dx_d     = -dx_q;
                bounce_d = 1'b1;
            end else begin
                x_d = nx[width_x-1:0];
            end

            if (ny < 0) begin
                y_d      = '0;
                dy_d     = -dy_q;
                bounce_d = 1'b1;
            end else if (ny > YMAX_S) begin
                y_d     = YMAX_C;
                lost_d  = 1'b1;
                state_d = IDLE;
            end else begin
                y_d = ny[width_y-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            x_q      <= '0;
            y_q      <= '0;
            dx_q     <= '0;
            dy_q     <= '0;
            bounce_q <= 1'b0;
            lost_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            dx_q     <= dx_d;
            dy_q     <= dy_d;
            bounce_q <= bounce_d;
            lost_q   <= lost_d;
        end
    end

    assign x      = x_q;
    assign y      = y_q;
    assign dx     = dx_q;
    assign dy     = dy_q;
    assign active = (state_q == MOVE);
    assign bounce = bounce_q;
    assign lost   = lost_q;

endmodule

// File: tb/tb_game_sprite_motion.sv
// Bench for game_sprite_motion: integer reference model checked every cycle,
// plus directed scenarios with literal expected values.
module tb_game_sprite_motion;

    localparam int WX = 10, WY = 10, WS = 4;
    localparam int XMAX = 640 - 8;
    localparam int YMAX = 480 - 8;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 strobe = 1'b0, launch = 1'b0, pause = 1'b0;
    logic [WX-1:0]        launch_x = '0;
    logic [WY-1:0]        launch_y = '0;
    logic signed [WS-1:0] launch_dx = '0, launch_dy = '0;
    logic [WX-1:0]        x;
    logic [WY-1:0]        y;
    logic signed [WS-1:0] dx, dy;
    logic                 active, bounce, lost;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Reference model state, plain integers.
    int mx = 0, my = 0, mdx = 0, mdy = 0;
    bit mact = 0, mb = 0, ml = 0;

    game_sprite_motion #(
        .width_x(WX), .width_y(WY), .width_step(WS),
        .screen_width(640), .screen_height(480),
        .sprite_width(8), .sprite_height(8)
    ) dut (
        .clk(clk), .reset(reset), .strobe(strobe), .launch(launch),
        .launch_x(launch_x), .launch_y(launch_y),
        .launch_dx(launch_dx), .launch_dy(launch_dy), .pause(pause),
        .x(x), .y(y), .dx(dx), .dy(dy),
        .active(active), .bounce(bounce), .lost(lost)
    );

    always #5 clk = ~clk;

    function automatic int sat(input int s);
        if (s == -(1 << (WS-1))) return s + 1;
        return s;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mx = 0; my = 0; mdx = 0; mdy = 0;
            mact = 0; mb = 0; ml = 0;
        end else begin
            int nx, ny;
            mb = 0; ml = 0;
            if (launch) begin
                mact = 1;
                mx  = (int'(launch_x) > XMAX) ? XMAX : int'(launch_x);
                my  = (int'(launch_y) > YMAX) ? YMAX : int'(launch_y);
                mdx = sat(int'(launch_dx));
                mdy = sat(int'(launch_dy));
            end else if (mact && strobe && !pause) begin
                nx = mx + mdx;
                ny = my + mdy;
                if (nx < 0)         begin mx = 0;    mdx = -mdx; mb = 1; end
                else if (nx > XMAX) begin mx = XMAX; mdx = -mdx; mb = 1; end
                else                mx = nx;
                if (ny < 0)         begin my = 0;    mdy = -mdy; mb = 1; end
                else if (ny > YMAX) begin my = YMAX; ml = 1; mact = 0; end
                else                my = ny;
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("m_x", int'(x), mx);
            check("m_y", int'(y), my);
            check("m_dx", int'(dx), mdx);
            check("m_dy", int'(dy), mdy);
            check("m_active", int'(active), int'(mact));
            check("m_bounce", int'(bounce), int'(mb));
            check("m_lost", int'(lost), int'(ml));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_launch(input int lx, input int ly, input int ldx, input int ldy, input bit with_strobe);
        launch_x  = WX'(lx);
        launch_y  = WY'(ly);
        launch_dx = WS'(ldx);
        launch_dy = WS'(ldy);
        launch    = 1'b1;
        strobe    = with_strobe;
        tick();
        launch = 1'b0;
        strobe = 1'b0;
    endtask

    task automatic strobes(input int n);
        strobe = 1'b1;
        repeat (n) tick();
        strobe = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        reset = 1'b0;
        chk_en = 1'b1;
        check("rst_x", int'(x), 0);
        check("rst_dx", int'(dx), 0);
        check("rst_active", int'(active), 0);
        check("rst_pulses", int'({bounce, lost}), 0);

        strobes(2);
        check("idle_strobe_x", int'(x), 0);

        // Basic step
        do_launch(100, 100, 3, -2, 1'b0);
        check("launch_active", int'(active), 1);
        strobes(1);
        check("step_x", int'(x), 103);
        check("step_y", int'(y), 98);
        check("step_bounce", int'(bounce), 0);
        strobes(3);
        check("step3_x", int'(x), 112);
        check("step3_y", int'(y), 92);

        // Left and top walls
        do_launch(2, 1, -5, -4, 1'b0);
        strobes(1);
        check("lt_x", int'(x), 0);
        check("lt_dx", int'(dx), 5);
        check("lt_y", int'(y), 0);
        check("lt_dy", int'(dy), 4);
        check("lt_bounce", int'(bounce), 1);
        tick();
        check("lt_bounce_end", int'(bounce), 0);

        // Right wall with launch clamp
        do_launch(700, 50, 4, 0, 1'b0);
        check("clamp_x", int'(x), 632);
        strobes(1);
        check("rw_x", int'(x), 632);
        check("rw_dx", int'(dx), -4);
        check("rw_bounce", int'(bounce), 1);
        check("rw_y", int'(y), 50);

        // Bottom loss
        do_launch(300, 470, 1, 3, 1'b0);
        strobes(1);
        check("loss_y", int'(y), 472);
        check("loss_x", int'(x), 301);
        check("loss_active", int'(active), 0);
        check("loss_lost", int'(lost), 1);
        strobes(5);
        check("lost_hold_x", int'(x), 301);
        check("lost_hold_lost", int'(lost), 0);
        check("lost_hold_dy", int'(dy), 3);

        // Right-wall bounce and bottom loss in the same step
        do_launch(631, 471, 3, 2, 1'b0);
        strobes(1);
        check("both_x", int'(x), 632);
        check("both_dx", int'(dx), -3);
        check("both_pulses", int'({bounce, lost}), 3);

        // Step saturation, launch priority, pause
        do_launch(10, 10, -8, -8, 1'b0);
        check("sat_dx", int'(dx), -7);
        check("sat_dy", int'(dy), -7);
        do_launch(50, 60, 2, 2, 1'b1);
        check("prio_x", int'(x), 50);
        check("prio_y", int'(y), 60);
        pause = 1'b1;
        strobes(3);
        check("pause_x", int'(x), 50);
        do_launch(20, 30, 1, 1, 1'b0);
        check("pause_launch_x", int'(x), 20);
        pause = 1'b0;
        strobes(1);
        check("after_pause_x", int'(x), 21);

        // Asynchronous reset mid-flight
        do_launch(100, 100, 3, -2, 1'b0);
        strobes(1);
        #2 reset = 1'b1;
        #1;
        check("arst_x", int'(x), 0);
        check("arst_y", int'(y), 0);
        check("arst_dx", int'(dx), 0);
        check("arst_active", int'(active), 0);
        #1 reset = 1'b0;
        strobes(3);
        check("post_rst_x", int'(x), 0);
        check("post_rst_active", int'(active), 0);

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
